// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, branch funct3 codes,
// multiply/divide operations and the iterative MD unit's state encoding.
package exe_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] MD_MUL  = 2'b00;
  localparam logic [1:0] MD_DIVU = 2'b01;
  localparam logic [1:0] MD_REMU = 2'b10;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative one-bit-per-cycle unsigned multiply (low half) and restoring divide.
// busy is the stall request: it covers the issue cycle and every BUSY cycle.
module muldiv_iter
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic [1:0]      state_reg;
  logic [CW-1:0]   count_reg;
  logic [1:0]      op_reg;
  logic [XLEN-1:0] acc_reg;
  logic [XLEN-1:0] opa_reg;
  logic [XLEN-1:0] opb_reg;
  logic            is_div;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;

  // Divide: acc holds the partial remainder, opa shifts the dividend out and quotient in.
  assign is_div    = (op_reg == MD_DIVU) || (op_reg == MD_REMU);
  assign rem_shift = {acc_reg, opa_reg[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, opb_reg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= MD_IDLE;
      count_reg <= '0;
      op_reg    <= '0;
      acc_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
    end else begin
      case (state_reg)
        MD_IDLE: begin
          if (start) begin
            op_reg    <= op;
            acc_reg   <= '0;
            opa_reg   <= a;
            opb_reg   <= b;
            count_reg <= '0;
            state_reg <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (is_div) begin
            if (!rem_diff[XLEN]) begin
              acc_reg <= rem_diff[XLEN-1:0];
              opa_reg <= {opa_reg[XLEN-2:0], 1'b1};
            end else begin
              acc_reg <= rem_shift[XLEN-1:0];
              opa_reg <= {opa_reg[XLEN-2:0], 1'b0};
            end
          end else begin
            if (opb_reg[0]) acc_reg <= acc_reg + opa_reg;
            opa_reg <= opa_reg << 1;
            opb_reg <= opb_reg >> 1;
          end
          count_reg <= count_reg + CW'(1);
          if (count_reg == CW'(XLEN - 1)) state_reg <= MD_DONE;
        end
        // DONE always returns to IDLE so the still-asserted start cannot retrigger.
        default: state_reg <= MD_IDLE;
      endcase
    end
  end

  assign busy   = ((state_reg == MD_IDLE) && start) || (state_reg == MD_BUSY);
  assign done   = (state_reg == MD_DONE);
  assign result = (op_reg == MD_DIVU) ? opa_reg : acc_reg;

endmodule

// File: rtl/execute_stage_md.sv
// EX stage with operand forwarding, ALU, branch resolution against the ID predictor,
// an optional iterative MUL/DIVU/REMU unit and the EX/MEM pipeline register.
module execute_stage_md
  import exe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int MD_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic [2:0]        BranchTypeE,
  input  logic [3:0]        ALUControlE,
  input  logic              ALUSrcE,
  input  logic              MDStartE,
  input  logic [1:0]        MDOpE,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   Imm_Ext_E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [XLEN-1:0]   ResultW,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic              PredictionE,
  input  logic [XLEN-1:0]   PredictedPCE,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCRedirectE,
  output logic              FlushE,
  output logic              StallE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   ALU_ResultM
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result, ex_result, target;
  logic [SHW-1:0]  shamt;
  logic            br_cond, taken;
  logic            md_stall, md_done;
  logic [XLEN-1:0] md_result;

  always_comb begin
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  assign shamt = src_b[SHW-1:0];

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(src_a) >>> shamt);
      default:  alu_result = '0;
    endcase
  end

  // The comparator always sees forwarded RD2, never the immediate.
  always_comb begin
    br_cond = 1'b0;
    case (BranchTypeE)
      BR_BEQ:  br_cond = (src_a == fwd_b);
      BR_BNE:  br_cond = (src_a != fwd_b);
      BR_BLT:  br_cond = ($signed(src_a) < $signed(fwd_b));
      BR_BGE:  br_cond = ($signed(src_a) >= $signed(fwd_b));
      BR_BLTU: br_cond = (src_a < fwd_b);
      BR_BGEU: br_cond = (src_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign target      = PCE + Imm_Ext_E;
  assign taken       = JumpE | (BranchE & br_cond);
  assign PCSrcE      = (taken != PredictionE) | (taken & PredictionE & (PredictedPCE != target));
  assign FlushE      = PCSrcE;
  assign PCRedirectE = taken ? target : PCPlus4E;

  generate
    if (MD_EN != 0) begin : g_md
      muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (MDStartE),
        .op     (MDOpE),
        .a      (src_a),
        .b      (fwd_b),
        .busy   (md_stall),
        .done   (md_done),
        .result (md_result)
      );
    end else begin : g_no_md
      assign md_stall  = 1'b0;
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  assign StallE    = md_stall;
  assign ex_result = md_done ? md_result : alu_result;

  // While stalled, M receives a bubble but keeps its data fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (StallE) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b;
      ALU_ResultM <= ex_result;
    end
  end

endmodule

// File: tb/tb_execute_stage_md.sv
// Self-checking bench for execute_stage_md: XLEN=32 main instance plus an XLEN=16
// instance for the MD latency check, with a behavioural reference model.
module tb_execute_stage_md;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE, MDStartE, PredictionE;
  logic [2:0]  BranchTypeE;
  logic [3:0]  ALUControlE;
  logic [1:0]  MDOpE, ForwardA_E, ForwardB_E;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, PredictedPCE;
  logic [4:0]  RD_E;
  logic        PCSrcE, FlushE, StallE, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCRedirectE, PCPlus4M, WriteDataM, ALU_ResultM;
  logic [4:0]  RD_M;

  logic        md_start16, pcsrc16, flush16, stall16, regwrite_m16, memwrite_m16, resultsrc_m16;
  logic [1:0]  md_op16;
  logic [15:0] a16, b16, redirect16, pcplus4_m16, writedata_m16, alu_result_m16;
  logic [4:0]  rd_m16;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_m = '0;
  logic [2:0]  br_types [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  execute_stage_md #(.XLEN(32), .REG_AW(5), .MD_EN(1)) dut (
    .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .BranchTypeE(BranchTypeE), .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE), .MDStartE(MDStartE), .MDOpE(MDOpE), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .PredictionE(PredictionE),
    .PredictedPCE(PredictedPCE), .PCSrcE(PCSrcE), .PCRedirectE(PCRedirectE), .FlushE(FlushE),
    .StallE(StallE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
  );

  execute_stage_md #(.XLEN(16), .REG_AW(5), .MD_EN(1)) dut16 (
    .clk(clk), .rst(rst), .RegWriteE(1'b1), .MemWriteE(1'b0), .ResultSrcE(1'b0),
    .BranchE(1'b0), .JumpE(1'b0), .BranchTypeE(3'b000), .ALUControlE(4'd0),
    .ALUSrcE(1'b0), .MDStartE(md_start16), .MDOpE(md_op16), .RD1_E(a16), .RD2_E(b16),
    .Imm_Ext_E(16'h0), .PCE(16'h0), .PCPlus4E(16'h4), .RD_E(5'd1), .ResultW(16'h0),
    .ForwardA_E(2'b00), .ForwardB_E(2'b00), .PredictionE(1'b0),
    .PredictedPCE(16'h0), .PCSrcE(pcsrc16), .PCRedirectE(redirect16), .FlushE(flush16),
    .StallE(stall16), .RegWriteM(regwrite_m16), .MemWriteM(memwrite_m16), .ResultSrcM(resultsrc_m16),
    .RD_M(rd_m16), .PCPlus4M(pcplus4_m16), .WriteDataM(writedata_m16), .ALU_ResultM(alu_result_m16)
  );

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << (b % 32);
      4'd8: return a >> (b % 32);
      4'd9: return $signed(a) >>> (b % 32);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input int xl);
    logic [63:0] m;
    m = (64'd1 << xl) - 64'd1;
    if (op == 2'b01) return (b == 0) ? m[31:0] : 32'(a / b);
    if (op == 2'b10) return (b == 0) ? a[31:0] : 32'(a % b);
    return 32'((a * b) & m);
  endfunction

  function automatic logic br_cond_ref(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; JumpE = 0; ALUSrcE = 0;
    MDStartE = 0; PredictionE = 0; BranchTypeE = 0; ALUControlE = 0; MDOpE = 0;
    ForwardA_E = 0; ForwardB_E = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0;
    PCPlus4E = 0; ResultW = 0; PredictedPCE = 0; RD_E = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    step(); step();
    checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0) begin
      errors++;
      $display("FAIL reset_m_outputs: got %b %b %b %h %h %h %h, required all 0", RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM);
    end
    checks++;
    if (StallE !== 1'b0 || PCSrcE !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_pcsrc: StallE=%b PCSrcE=%b, required 0 0", StallE, PCSrcE);
    end
    rst = 1;
    step();
    exp_m = '0;
  endtask

  task automatic do_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hold_m, wd, exp_r;
    int n;
    hold_m = exp_m; n = 0; exp_r = md_ref(op, a, b, 32);
    clear_inputs();
    RegWriteE = 1; MemWriteE = 1; MDStartE = 1; MDOpE = op; RD1_E = a; RD2_E = b;
    RD_E = 5'($urandom); PCPlus4E = $urandom;
    #1;
    while (StallE === 1'b1 && n < 200) begin
      step();
      n++;
      checks++;
      if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || ALU_ResultM !== hold_m) begin
        errors++;
        $display("FAIL md_bubble op=%0d cycle=%0d: RegWriteM=%b MemWriteM=%b ALU_ResultM=%h, required 0 0 %h", op, n, RegWriteM, MemWriteM, ALU_ResultM, hold_m);
      end
      // Operands are latched at issue, so disturbing them now must not matter.
      RD1_E = $urandom; RD2_E = $urandom; ForwardA_E = 2'($urandom_range(0, 3));
    end
    wd = $urandom; RD2_E = wd; ForwardA_E = 0;
    checks++;
    if (n !== XLEN + 1) begin
      errors++;
      $display("FAIL md_stall_len op=%0d: stalled %0d cycles, required %0d", op, n, XLEN + 1);
    end
    step();
    checks++;
    if (ALU_ResultM !== exp_r) begin
      errors++;
      $display("FAIL md_result op=%0d a=%h b=%h: got %h, required %h", op, a, b, ALU_ResultM, exp_r);
    end
    checks++;
    if ({RegWriteM, MemWriteM, WriteDataM} !== {1'b1, 1'b1, wd}) begin
      errors++;
      $display("FAIL md_capture: got %b %b %h, required 1 1 %h", RegWriteM, MemWriteM, WriteDataM, wd);
    end
    exp_m = exp_r;
    MDStartE = 0; RegWriteE = 0; MemWriteE = 0;
    #1;
    checks++;
    if (StallE !== 1'b0) begin
      errors++;
      $display("FAIL md_restart: StallE=%b after DONE, required 0", StallE);
    end
    $display("md op=%0d a=%h b=%h result=%h stall_cycles=%0d", op, a, b, ALU_ResultM, n);
  endtask

  task automatic test_forward();
    logic [31:0] req [4] = '{32'd7, 32'd2, 32'd4, 32'd7};
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin RD1_E = 3; RD2_E = 4; ALUControlE = 4'd0; end
        1: begin RD1_E = 999; RD2_E = 5; ForwardA_E = 2'b10; ALUControlE = 4'd1; end
        2: begin RD1_E = 5; ForwardA_E = 2'b00; ForwardB_E = 2'b01; ResultW = 32'hFFFF_FFFF; ALUControlE = 4'd0; end
        default: begin RD1_E = 10; RD2_E = 3; ForwardA_E = 2'b11; ForwardB_E = 2'b00; ALUControlE = 4'd1; end
      endcase
      step();
      checks++;
      if (ALU_ResultM !== req[i]) begin
        errors++;
        $display("FAIL forward_%0d: ALU_ResultM=%h, required %h", i, ALU_ResultM, req[i]);
      end
      $display("forward case %0d result=%h", i, ALU_ResultM);
    end
    exp_m = 32'd7;
  endtask

  task automatic test_alu_random();
    logic [31:0] fa, fb, bop, er;
    logic [72:0] exp_ctrl;
    clear_inputs();
    for (int i = 0; i < 60; i++) begin
      ALUControlE = 4'($urandom_range(0, 11));
      RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom; ResultW = $urandom;
      ALUSrcE = 1'($urandom_range(0, 1));
      ForwardA_E = 2'($urandom_range(0, 3)); ForwardB_E = 2'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1)); MemWriteE = 1'($urandom_range(0, 1));
      ResultSrcE = 1'($urandom_range(0, 1)); RD_E = 5'($urandom); PCPlus4E = $urandom;
      fa = (ForwardA_E == 2'b01) ? ResultW : (ForwardA_E == 2'b10) ? exp_m : RD1_E;
      fb = (ForwardB_E == 2'b01) ? ResultW : (ForwardB_E == 2'b10) ? exp_m : RD2_E;
      bop = ALUSrcE ? Imm_Ext_E : fb;
      er = alu_ref(ALUControlE, fa, bop);
      exp_ctrl = {RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E, fb};
      step();
      checks++;
      if (ALU_ResultM !== er) begin
        errors++;
        $display("FAIL alu_op%0d: a=%h b=%h ALU_ResultM=%h, required %h", ALUControlE, fa, bop, ALU_ResultM, er);
      end
      checks++;
      if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM} !== exp_ctrl) begin
        errors++;
        $display("FAIL alu_capture: got %h, required %h", {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM}, exp_ctrl);
      end
      exp_m = er;
      $display("alu op=%0d a=%h b=%h result=%h", ALUControlE, fa, bop, ALU_ResultM);
    end
  endtask

  task automatic test_mul();
    do_md(2'b00, 32'h0001_0000, 32'h0001_0000);
    do_md(2'b00, 32'd6, 32'd7);
    do_md(2'b11, 32'd9, 32'd11);
    for (int i = 0; i < 3; i++) do_md(2'b00, $urandom, $urandom);
  endtask

  task automatic test_divu();
    do_md(2'b01, 32'd100, 32'd7);
    do_md(2'b10, 32'd100, 32'd7);
    do_md(2'b01, 32'hDEAD_BEEF, 32'd0);
    do_md(2'b10, 32'd9, 32'd0);
    for (int i = 0; i < 3; i++) do_md(2'($urandom_range(1, 2)), $urandom, 32'($urandom_range(1, 70000)));
  endtask

  task automatic test_back_to_back();
    logic [31:0] er;
    do_md(2'b00, 32'd123, 32'd456);
    do_md(2'b01, 32'hFFFF_FFFF, 32'd3);
    RD1_E = $urandom; RD2_E = $urandom; ALUControlE = 4'd4; RegWriteE = 1;
    er = RD1_E ^ RD2_E;
    step();
    checks++;
    if (ALU_ResultM !== er || StallE !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_alu: ALU_ResultM=%h StallE=%b, required %h 0", ALU_ResultM, StallE, er);
    end
    exp_m = er;
  endtask

  task automatic test_reset_mid_divu();
    clear_inputs();
    MDStartE = 1; MDOpE = 2'b01; RD1_E = 100; RD2_E = 7; RegWriteE = 1;
    repeat (11) step();
    checks++;
    if (StallE !== 1'b1) begin
      errors++;
      $display("FAIL mid_divu_busy: StallE=%b, required 1", StallE);
    end
    rst = 0;
    clear_inputs();
    #1;
    checks++;
    if (StallE !== 1'b0 || {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0) begin
      errors++;
      $display("FAIL mid_divu_reset: StallE=%b ALU_ResultM=%h RD_M=%h, required 0 and all M outputs 0", StallE, ALU_ResultM, RD_M);
    end
    step();
    rst = 1;
    step(); step();
    checks++;
    if (ALU_ResultM !== 32'd0 || RegWriteM !== 1'b0) begin
      errors++;
      $display("FAIL mid_divu_no_write: ALU_ResultM=%h RegWriteM=%b, required 0 0", ALU_ResultM, RegWriteM);
    end
    exp_m = '0;
    do_md(2'b01, 32'd100, 32'd7);
  endtask

  task automatic test_branch_directed();
    logic [31:0] req_pc [5] = '{32'h120, 32'h104, 32'h120, 32'h120, 32'h104};
    logic        req_mis [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    clear_inputs();
    PCE = 32'h100; PCPlus4E = 32'h104; Imm_Ext_E = 32'h20; ALUSrcE = 1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin BranchE = 1; BranchTypeE = 3'b100; RD1_E = 32'hFFFF_FFFF; RD2_E = 1; PredictionE = 0; end
        1: begin BranchTypeE = 3'b110; end
        2: begin BranchTypeE = 3'b000; RD1_E = 5; RD2_E = 5; PredictionE = 1; PredictedPCE = 32'h124; end
        3: begin PredictedPCE = 32'h120; end
        default: begin BranchE = 0; PredictionE = 1; end
      endcase
      #1;
      checks++;
      if (PCSrcE !== req_mis[i] || FlushE !== req_mis[i] || PCRedirectE !== req_pc[i]) begin
        errors++;
        $display("FAIL branch_dir_%0d: PCSrcE=%b FlushE=%b PCRedirectE=%h, required %b %b %h", i, PCSrcE, FlushE, PCRedirectE, req_mis[i], req_mis[i], req_pc[i]);
      end
      $display("branch case %0d PCSrcE=%b PCRedirectE=%h", i, PCSrcE, PCRedirectE);
    end
  endtask

  task automatic test_branch_random();
    logic [31:0] a, b, tgt, redir;
    logic        tk, mis;
    for (int i = 0; i < 60; i++) begin
      step();
      clear_inputs();
      a = $urandom_range(0, 1) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 7))) : 32'($urandom_range(0, 7));
      b = $urandom_range(0, 1) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 7))) : 32'($urandom_range(0, 7));
      RD1_E = a; RD2_E = b; ALUSrcE = 1'($urandom_range(0, 1));
      BranchE = 1'($urandom_range(0, 1)); JumpE = ($urandom_range(0, 7) == 0);
      BranchTypeE = br_types[$urandom_range(0, 5)];
      Imm_Ext_E = $urandom & 32'hFFFF_FFFE; PCE = $urandom & 32'hFFFF_FFFC; PCPlus4E = PCE + 4;
      PredictionE = 1'($urandom_range(0, 1));
      tgt = PCE + Imm_Ext_E;
      PredictedPCE = $urandom_range(0, 1) ? tgt : tgt + 32'(4 * $urandom_range(1, 3));
      tk = JumpE || (BranchE && br_cond_ref(BranchTypeE, a, b));
      mis = (tk != PredictionE) || (tk && PredictionE && PredictedPCE != tgt);
      redir = tk ? tgt : PCPlus4E;
      #1;
      checks++;
      if (PCSrcE !== mis || FlushE !== mis || PCRedirectE !== redir) begin
        errors++;
        $display("FAIL branch_rand type=%b a=%h b=%h: PCSrcE=%b FlushE=%b PCRedirectE=%h, required %b %b %h", BranchTypeE, a, b, PCSrcE, FlushE, PCRedirectE, mis, mis, redir);
      end
      $display("branch type=%b a=%h b=%h taken=%b PCSrcE=%b", BranchTypeE, a, b, tk, PCSrcE);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_xlen16();
    logic [1:0]  ops [3] = '{2'b01, 2'b00, 2'b10};
    logic [15:0] av [3] = '{16'd1000, 16'd300, 16'd9};
    logic [15:0] bv [3] = '{16'd7, 16'd300, 16'd0};
    logic [31:0] r;
    int n;
    for (int i = 0; i < 3; i++) begin
      md_start16 = 1; md_op16 = ops[i]; a16 = av[i]; b16 = bv[i]; n = 0;
      r = md_ref(ops[i], {48'd0, av[i]}, {48'd0, bv[i]}, 16);
      #1;
      while (stall16 === 1'b1 && n < 100) begin
        step();
        n++;
      end
      checks++;
      if (n !== 17) begin
        errors++;
        $display("FAIL x16_stall_len op=%0d: stalled %0d cycles, required 17", ops[i], n);
      end
      step();
      checks++;
      if (alu_result_m16 !== r[15:0]) begin
        errors++;
        $display("FAIL x16_result op=%0d: got %h, required %h", ops[i], alu_result_m16, r[15:0]);
      end
      md_start16 = 0;
      $display("md16 op=%0d a=%h b=%h result=%h stall_cycles=%0d", ops[i], av[i], bv[i], alu_result_m16, n);
    end
  endtask

  initial begin
    md_start16 = 0; md_op16 = 0; a16 = 0; b16 = 0;
    clear_inputs();
    test_reset();
    test_forward();
    test_alu_random();
    test_mul();
    test_divu();
    test_back_to_back();
    test_reset_mid_divu();
    test_branch_directed();
    test_branch_random();
    test_xlen16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
